instruction_loader: RTL and testbench
=====================================

# instruction_loader

Sequential loader that writes the program the `control_id` decoder later consumes. It takes a byte stream from the debug UART receiver and assembles big-endian 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses. The CPU pipeline is held in reset/stall while a load is in progress. A load ends on the HALT word 32'hFFFFFFFF, or with an error if memory fills before HALT arrives.

## Interface

Parameters:
- NB_data, 32, instruction word width
- NB_addr, 5, instruction memory word-address width (depth 2^NB_addr = 32 words)

Ports (one clock; reset is asynchronous and active-high):
- in_clk  input  1  system clock, all state on rising edge
- in_reset  input  1  asynchronous, active-high reset
- in_start  input  1  single-cycle pulse, begins a load
- in_rx_data  input  8  received byte
- in_rx_valid  input  1  in_rx_data valid this cycle
- out_rx_ready  output  1  loader accepts a byte this cycle
- out_wr_en  output  1  instruction memory write strobe, one cycle per word
- out_wr_addr  output  NB_addr  word address for the write
- out_wr_data  output  NB_data  assembled instruction word
- out_cpu_hold  output  1  holds CPU fetch/pipeline while loading
- out_done  output  1  level, load ended with HALT
- out_error  output  1  level, memory full without HALT
- out_word_count  output  NB_addr+1  words written in the current/last load

## Operation

- States:
  - IDLE: waits for in_start.
  - RECV: collects bytes.
  - WRITE: issues the memory write.
  - DONE: terminal, load ended with HALT.
  - ERROR: terminal, memory full without HALT.
- Byte accepted only when in_rx_valid && out_rx_ready. out_rx_ready = 1 only in RECV.
- Byte assembly: the first accepted byte is bits [31:24] and the fourth is bits [7:0] (MSB first). Example: bytes 8C,20,00,00 give 32'h8C200000.
- Byte counter: 2 bits, wraps 3→0 on the fourth byte.
- Transitions:
  - IDLE→RECV on in_start. Word count, byte counter and write address clear to 0.
  - RECV→WRITE on acceptance of the fourth byte.
  - WRITE (1 cycle): out_wr_en=1. Word count increments and address increments (mod 2^NB_addr). Then:
    - word == HALT → DONE.
    - else count reaches 2^NB_addr → ERROR.
    - else → RECV.
  - DONE/ERROR→RECV on in_start, which restarts the load from address 0 with count 0.
- The HALT word is written to memory and counted.
- If HALT lands in the last slot (address 2^NB_addr−1), the result is DONE, not ERROR.
- in_start is ignored in RECV and WRITE.
- in_rx_valid is ignored outside RECV; those bytes are dropped.
- out_cpu_hold = 1 in RECV and WRITE, 0 otherwise.
- out_done = 1 only in DONE. out_error = 1 only in ERROR.

## Timing

- Reset values (asynchronous, immediate): state IDLE, all outputs 0, out_wr_addr 0, out_wr_data 0, word count 0, partial word cleared.
- Reset mid-load: the partial word is discarded and no write is issued. Memory contents are unspecified.
- in_start sampled at edge t → RECV at t+1; out_rx_ready and out_cpu_hold are 1 from t+1.
- Fourth byte accepted at edge t → out_wr_en=1 with valid addr/data during cycle t+1. out_rx_ready=0 during that cycle.
- Back in RECV (or DONE/ERROR) at t+2.
- Minimum of 5 cycles per word. out_word_count updates at t+2.
- out_wr_data and out_wr_addr hold their last values outside WRITE.

## Structure

- Shared package `loader_pkg`:
  - state encoding typedef (IDLE, RECV, WRITE, DONE, ERROR)
  - HALT_WORD = 32'hFFFFFFFF
  - default NB_data/NB_addr
- Sub-module `byte_assembler`: 32-bit shift register plus 2-bit byte counter with clear and accept inputs. Outputs are the word and a word_complete pulse.
- The top module owns the FSM, address and count.

## Test plan

- Reset asserted mid-cycle → all outputs 0 immediately; in_rx_valid with 0xAA while IDLE → no write, out_rx_ready stays 0.
- in_start, bytes 8C,20,00,00 → one out_wr_en cycle, addr 0, data 32'h8C200000, out_word_count=1, out_cpu_hold=1.
- in_start, words 22D5FFCE, 012A4020, FFFFFFFF → writes at addr 0,1,2, out_done=1, out_cpu_hold=0, out_word_count=3, further bytes ignored.
- 32 non-HALT words → 32 writes, addr 31 last, out_error=1, count=32. Separately, 31 words + HALT → out_done=1, count=32.
- Two bytes sent, in_reset pulsed, then in_start with bytes 12,43,A8,20 → a single write at addr 0 with data 32'h1243A820.
- in_start pulsed during RECV → ignored, assembly continues. In DONE, in_start → restart at addr 0, count 0, out_done deasserts.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, HALT marker
// and default widths.
package loader_pkg;

  localparam int DEF_NB_DATA = 32;
  localparam int DEF_NB_ADDR = 5;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Shifts received bytes MSB-first into a 32-bit word; flags the byte that
// completes the word so the caller can act on the same edge.
module byte_assembler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_complete
);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_accept) begin
      r_shift <= {r_shift[23:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word          = r_shift;
  assign o_word_complete = i_accept && (r_cnt == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads big-endian instruction words from a byte stream into instruction
// memory, holding the CPU until HALT arrives or memory fills.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int NB_data = DEF_NB_DATA,
  parameter int NB_addr = DEF_NB_ADDR
) (
  input  logic               in_clk,
  input  logic               in_reset,
  input  logic               in_start,
  input  logic [7:0]         in_rx_data,
  input  logic               in_rx_valid,
  output logic               out_rx_ready,
  output logic               out_wr_en,
  output logic [NB_addr-1:0] out_wr_addr,
  output logic [NB_data-1:0] out_wr_data,
  output logic               out_cpu_hold,
  output logic               out_done,
  output logic               out_error,
  output logic [NB_addr:0]   out_word_count,
  output logic [2:0]         out_dbg_state
);

  localparam logic [NB_addr:0] LAST_COUNT = (NB_addr+1)'((1 << NB_addr) - 1);

  state_t             r_state;
  logic [NB_addr-1:0] r_next_addr;
  logic [NB_addr-1:0] r_wr_addr;
  logic [NB_data-1:0] r_wr_data;
  logic [NB_addr:0]   r_count;

  logic        w_start;
  logic        w_accept;
  logic        w_word_complete;
  logic [31:0] w_word;

  assign w_start  = in_start && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign w_accept = in_rx_valid && (r_state == ST_RECV);

  byte_assembler u_asm (
    .i_clk           (in_clk),
    .i_rst           (in_reset),
    .i_clear         (w_start),
    .i_accept        (w_accept),
    .i_byte          (in_rx_data),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state     <= ST_IDLE;
      r_next_addr <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (in_start) begin
            r_state     <= ST_RECV;
            r_count     <= '0;
            r_next_addr <= '0;
          end
        end
        ST_RECV: begin
          if (w_word_complete) begin
            r_state   <= ST_WRITE;
            r_wr_addr <= r_next_addr;
          end
        end
        ST_WRITE: begin
          // HALT is checked first so a HALT in the last slot ends as DONE.
          r_wr_data   <= w_word;
          r_count     <= r_count + 1'b1;
          r_next_addr <= r_next_addr + 1'b1;
          if (w_word == HALT_WORD)
            r_state <= ST_DONE;
          else if (r_count == LAST_COUNT)
            r_state <= ST_ERROR;
          else
            r_state <= ST_RECV;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The shift register is only stable as the full word during WRITE; the
  // captured copy keeps the data bus steady afterwards.
  assign out_wr_data    = (r_state == ST_WRITE) ? w_word : r_wr_data;
  assign out_wr_addr    = r_wr_addr;
  assign out_wr_en      = (r_state == ST_WRITE);
  assign out_rx_ready   = (r_state == ST_RECV);
  assign out_cpu_hold   = (r_state == ST_RECV) || (r_state == ST_WRITE);
  assign out_done       = (r_state == ST_DONE);
  assign out_error      = (r_state == ST_ERROR);
  assign out_word_count = r_count;
  assign out_dbg_state  = r_state;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: reset, word assembly, HALT, memory
// full, mid-load reset and in_start handling.
module tb_instruction_loader;

  logic        in_clk = 1'b0;
  logic        in_reset;
  logic        in_start;
  logic [7:0]  in_rx_data;
  logic        in_rx_valid;
  logic        out_rx_ready;
  logic        out_wr_en;
  logic [4:0]  out_wr_addr;
  logic [31:0] out_wr_data;
  logic        out_cpu_hold;
  logic        out_done;
  logic        out_error;
  logic [5:0]  out_word_count;
  logic [2:0]  out_dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [36:0] exp_q[$];
  logic [36:0] got_q[$];

  instruction_loader #(.NB_data(32), .NB_addr(5)) dut (
    .in_clk         (in_clk),
    .in_reset       (in_reset),
    .in_start       (in_start),
    .in_rx_data     (in_rx_data),
    .in_rx_valid    (in_rx_valid),
    .out_rx_ready   (out_rx_ready),
    .out_wr_en      (out_wr_en),
    .out_wr_addr    (out_wr_addr),
    .out_wr_data    (out_wr_data),
    .out_cpu_hold   (out_cpu_hold),
    .out_done       (out_done),
    .out_error      (out_error),
    .out_word_count (out_word_count),
    .out_dbg_state  (out_dbg_state)
  );

  // clock / reset
  always #5 in_clk = ~in_clk;

  // write monitor
  always @(negedge in_clk) begin
    if (out_wr_en === 1'b1) got_q.push_back({out_wr_addr, out_wr_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, 64'(out_rx_ready), 64'd0);
    check({tag, "_wr_en"}, 64'(out_wr_en), 64'd0);
    check({tag, "_addr"},  64'(out_wr_addr), 64'd0);
    check({tag, "_data"},  64'(out_wr_data), 64'd0);
    check({tag, "_hold"},  64'(out_cpu_hold), 64'd0);
    check({tag, "_done"},  64'(out_done), 64'd0);
    check({tag, "_error"}, 64'(out_error), 64'd0);
    check({tag, "_count"}, 64'(out_word_count), 64'd0);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_wr%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic pulse_reset();
    @(negedge in_clk);
    in_reset = 1'b1;
    @(negedge in_clk);
    in_reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge in_clk);
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 16 && !ok; k++) begin
      @(negedge in_clk);
      in_rx_data  = b;
      in_rx_valid = 1'b1;
      if (out_rx_ready === 1'b1) begin
        @(posedge in_clk);
        #1;
        in_rx_valid = 1'b0;
        ok = 1'b1;
      end
    end
    in_rx_valid = 1'b0;
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("FAIL send_timeout: byte %0h not accepted, observed ready %0b expected 1", b, out_rx_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  initial begin
    in_reset    = 1'b1;
    in_start    = 1'b0;
    in_rx_data  = 8'h00;
    in_rx_valid = 1'b0;

    // reset state, bytes while IDLE are dropped
    #3;
    check_zero_outputs("reset");
    idle(1);
    in_reset = 1'b0;
    in_rx_data  = 8'hAA;
    in_rx_valid = 1'b1;
    idle(3);
    check("idle_ready", 64'(out_rx_ready), 64'd0);
    in_rx_valid = 1'b0;
    idle(2);
    check_writes("idle");

    // single word, write-cycle timing
    pulse_start();
    check("start_ready", 64'(out_rx_ready), 64'd1);
    check("start_hold", 64'(out_cpu_hold), 64'd1);
    send_word(32'h8C20_0000);
    @(negedge in_clk);
    check("w1_wr_en", 64'(out_wr_en), 64'd1);
    check("w1_ready_in_write", 64'(out_rx_ready), 64'd0);
    check("w1_count_before", 64'(out_word_count), 64'd0);
    @(negedge in_clk);
    check("w1_count", 64'(out_word_count), 64'd1);
    check("w1_hold", 64'(out_cpu_hold), 64'd1);
    check("w1_ready_back", 64'(out_rx_ready), 64'd1);
    check("w1_data_held", 64'(out_wr_data), 64'h8C20_0000);
    exp_q.push_back({5'd0, 32'h8C20_0000});
    check_writes("w1");

    // three words ending on HALT
    pulse_reset();
    pulse_start();
    send_word(32'h22D5_FFCE);
    send_word(32'h012A_4020);
    send_word(32'hFFFF_FFFF);
    idle(2);
    exp_q.push_back({5'd0, 32'h22D5_FFCE});
    exp_q.push_back({5'd1, 32'h012A_4020});
    exp_q.push_back({5'd2, 32'hFFFF_FFFF});
    check_writes("halt3");
    check("halt3_done", 64'(out_done), 64'd1);
    check("halt3_error", 64'(out_error), 64'd0);
    check("halt3_hold", 64'(out_cpu_hold), 64'd0);
    check("halt3_count", 64'(out_word_count), 64'd3);
    in_rx_data  = 8'h55;
    in_rx_valid = 1'b1;
    idle(6);
    in_rx_valid = 1'b0;
    check("done_ready", 64'(out_rx_ready), 64'd0);
    check("done_count_hold", 64'(out_word_count), 64'd3);
    check_writes("done_ignore");

    // restart from DONE
    pulse_start();
    check("restart_done_low", 64'(out_done), 64'd0);
    check("restart_count", 64'(out_word_count), 64'd0);
    check("restart_ready", 64'(out_rx_ready), 64'd1);
    send_word(32'hAABB_CCDD);
    idle(2);
    exp_q.push_back({5'd0, 32'hAABB_CCDD});
    check_writes("restart");

    // memory fills without HALT
    pulse_reset();
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      send_word(32'h1000_0000 + 32'(i));
      exp_q.push_back({5'(i), 32'h1000_0000 + 32'(i)});
    end
    idle(2);
    check_writes("full");
    check("full_error", 64'(out_error), 64'd1);
    check("full_done", 64'(out_done), 64'd0);
    check("full_count", 64'(out_word_count), 64'd32);
    check("full_hold", 64'(out_cpu_hold), 64'd0);
    check("full_last_addr", 64'(out_wr_addr), 64'd31);

    // HALT in the last slot
    pulse_reset();
    pulse_start();
    for (int i = 0; i < 31; i++) begin
      send_word(32'h2000_0000 + 32'(i));
      exp_q.push_back({5'(i), 32'h2000_0000 + 32'(i)});
    end
    send_word(32'hFFFF_FFFF);
    exp_q.push_back({5'd31, 32'hFFFF_FFFF});
    idle(2);
    check_writes("halt_last");
    check("halt_last_done", 64'(out_done), 64'd1);
    check("halt_last_error", 64'(out_error), 64'd0);
    check("halt_last_count", 64'(out_word_count), 64'd32);

    // reset mid-load discards the partial word
    pulse_start();
    send_byte(8'hDE);
    send_byte(8'hAD);
    @(negedge in_clk);
    #2;
    in_reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    @(negedge in_clk);
    in_reset = 1'b0;
    pulse_start();
    send_word(32'h1243_A820);
    idle(2);
    exp_q.push_back({5'd0, 32'h1243_A820});
    check_writes("after_reset");
    check("after_reset_count", 64'(out_word_count), 64'd1);

    // in_start during RECV is ignored
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_start();
    check("recv_start_ready", 64'(out_rx_ready), 64'd1);
    check("recv_start_count", 64'(out_word_count), 64'd1);
    send_byte(8'h03);
    send_byte(8'h04);
    idle(2);
    exp_q.push_back({5'd1, 32'h0102_0304});
    check_writes("recv_start");
    check("recv_start_count2", 64'(out_word_count), 64'd2);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
